// File: rtl/lcd_value_display.sv
// lcd_value_display: converts two 16-bit values to decimal, builds the two-line
// message for lcd_init and hands it over with a sendText/sendingDone handshake.
module lcd_value_display #(
    parameter int          TEXT_LENGTH = 34,
    parameter logic [15:0] LABEL_A     = "A=",
    parameter logic [15:0] LABEL_B     = "B=",
    parameter bit          BLANK_ZEROS = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [15:0]              value_a,
    input  logic [15:0]              value_b,
    input  logic                     update,
    input  logic                     sendingDone,
    output logic                     sendText,
    output logic [8*TEXT_LENGTH:1]   text,
    output logic                     busy
);
    typedef enum logic [2:0] {IDLE, CONV_A, CONV_B, BUILD, SEND, WAIT_LOW, WAIT_HIGH} stateType;

    localparam logic [8*TEXT_LENGTH:1] RESET_TEXT = {8'h0A, {16{8'h20}}, 8'h0A, {16{8'h20}}};

    stateType    state;
    logic        pending;
    logic [4:0]  cnt;
    logic [35:0] sr;
    logic [35:0] srNext;
    logic [15:0] capB;
    logic [19:0] bcdA;

    // One double-dabble iteration: add 3 to each BCD digit >= 5, then shift left.
    function automatic logic [35:0] ddStep(input logic [35:0] s);
        logic [35:0] t;
        t = s;
        for (int i = 0; i < 5; i++)
            if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        return {t[34:0], 1'b0};
    endfunction

    function automatic logic [39:0] toAscii(input logic [19:0] bcd);
        logic [39:0] r;
        logic        lead;
        lead = BLANK_ZEROS;
        for (int i = 4; i >= 0; i--) begin
            lead = lead && (bcd[4*i +: 4] == 4'd0) && (i != 0);
            r[8*i +: 8] = lead ? 8'h20 : {4'h3, bcd[4*i +: 4]};
        end
        return r;
    endfunction

    assign srNext = ddStep(sr);
    assign busy   = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            pending  <= 1'b0;
            cnt      <= '0;
            sr       <= '0;
            capB     <= '0;
            bcdA     <= '0;
            sendText <= 1'b0;
            text     <= RESET_TEXT;
        end else begin
            // Registered from SEND so the pulse lands on the edge that leaves SEND.
            sendText <= (state == SEND);
            if (update && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: if (update || pending) begin
                    state   <= CONV_A;
                    sr      <= {20'd0, value_a};
                    capB    <= value_b;
                    pending <= 1'b0;
                    cnt     <= '0;
                end
                CONV_A: begin
                    cnt <= (cnt == 5'd15) ? 5'd0 : cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        bcdA  <= srNext[35:16];
                        sr    <= {20'd0, capB};
                        state <= CONV_B;
                    end else begin
                        sr <= srNext;
                    end
                end
                CONV_B: begin
                    cnt <= (cnt == 5'd15) ? 5'd0 : cnt + 5'd1;
                    sr  <= srNext;
                    if (cnt == 5'd15) state <= BUILD;
                end
                BUILD: begin
                    text  <= {8'h0A, LABEL_A, toAscii(bcdA), {9{8'h20}},
                              8'h0A, LABEL_B, toAscii(sr[35:16]), {9{8'h20}}};
                    state <= SEND;
                end
                SEND:      state <= WAIT_LOW;
                WAIT_LOW:  if (!sendingDone) state <= WAIT_HIGH;
                WAIT_HIGH: if (sendingDone) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule
